riscv_ctrl_fsm: RTL and testbench

- Multicycle RV32 control unit: the driving end of the ALU interface.
- Generates ALUControl and the ALU operand selects, and consumes the ALU's Zero flag to resolve branches.
- Also sequences fetch, decode, memory access and register writeback for lw, sw, R-type, I-type ALU, beq, bne and jal.
- Timing is built around an ALU with one-cycle registered latency: ALUResult is valid one cycle after issue, Zero is valid two cycles after issue.

---
 rtl/riscv_ctrl_fsm.sv | 168 ++++++++++++++++
 tb/tb_riscv_ctrl_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_ctrl_fsm.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute and drives
// the ALU operand selects and operation, resolving branches from Zero.
module riscv_ctrl_fsm #(
    parameter int RESET_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR,
        MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, BRWAIT,
        BRCHK, BRTGT, JAL, PCWB
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] IDLE_LAST = 4'(RESET_DELAY - 1);

    state_t     state, next;
    logic [3:0] cnt;
    logic [3:0] funct_alu;
    logic       taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next;
            cnt   <= (state == IDLE && next == IDLE) ? cnt + 4'd1 : 4'd0;
        end
    end

    // srai shares funct3 101 with srli, so only there does funct7b5 matter
    assign funct_alu = (op == OP_I && funct3 != 3'b101) ?
                       {1'b0, funct3} : {funct7b5, funct3};
    assign taken = Zero ^ funct3[0];

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        next          = IDLE;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        illegal_instr = 1'b0;
        case (state)
            IDLE: next = (cnt == IDLE_LAST) ? FETCH : IDLE;
            FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = 2'b10;
                next    = DECODE;
            end
            DECODE: begin
                PCWrite = 1'b1;
                if (op == OP_LW || op == OP_SW)
                    next = MEMADR;
                else if (op == OP_R)
                    next = EXECR;
                else if (op == OP_I)
                    next = EXECI;
                else if (op == OP_BR && funct3[2:1] == 2'b00)
                    next = BRANCH;
                else if (op == OP_JAL)
                    next = JAL;
                else begin
                    illegal_instr = 1'b1;
                    next          = FETCH;
                end
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                next    = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                next   = MEMWB;
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                ResultSrc = 2'b01;
                next      = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                next     = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = funct_alu;
                next       = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = funct_alu;
                next       = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                next     = FETCH;
            end
            // SUB is held for two cycles to cover the ALU's Zero latency
            BRANCH, BRWAIT: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                next       = (state == BRANCH) ? BRWAIT : BRCHK;
            end
            BRCHK: next = taken ? BRTGT : FETCH;
            BRTGT: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                next    = PCWB;
            end
            JAL: begin
                RegWrite  = 1'b1;
                ResultSrc = 2'b10;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b01;
                next      = PCWB;
            end
            PCWB: begin
                PCWrite = 1'b1;
                next    = FETCH;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Scoreboard bench for riscv_ctrl_fsm: per-cycle expected control words
// are queued by the driver and checked by an independent monitor.
module tb_riscv_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl;
    logic       illegal_instr;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [17:0] v;
    } exp_t;
    exp_t q[$];

    riscv_ctrl_fsm #(.RESET_DELAY(2)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    logic [17:0] act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};

    function automatic logic [17:0] v(
        input logic pcw, input logic adr, input logic mw, input logic irw,
        input logic rw, input logic [1:0] rs, input logic [1:0] a,
        input logic [1:0] b, input logic [1:0] imm, input logic [3:0] alu,
        input logic ill);
        return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
    endfunction

    // monitor: every cycle the DUT presents a control word
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_chk++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.v);
                end
            end
        end
    end

    task automatic cyc(input string name, input logic [17:0] e);
        exp_t x;
        x.name = name;
        x.v = e;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input logic [6:0] o, input logic [2:0] f3,
                         input logic f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    task automatic fetch_decode(input logic [1:0] imm, input logic ill);
        cyc("fetch", v(0,0,0,1,0,2'd0,2'd0,2'd2,imm,4'd0,0));
        cyc("decode", v(1,0,0,0,0,2'd0,2'd0,2'd0,imm,4'd0,ill));
    endtask

    task automatic do_lw();
        setin(7'b0000011, 3'b010, 1'b0);
        fetch_decode(2'd0, 0);
        cyc("lw_memadr", v(0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,4'd0,0));
        cyc("lw_memread", v(0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,4'd0,0));
        cyc("lw_memwb", v(0,0,0,0,1,2'd1,2'd0,2'd0,2'd0,4'd0,0));
    endtask

    task automatic do_alu(input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic isi,
                          input logic [3:0] alu);
        setin(o, f3, f7);
        fetch_decode(2'd0, 0);
        cyc(isi ? "execi" : "execr",
            v(0,0,0,0,0,2'd0,2'd2,{1'b0, isi},2'd0,alu,0));
        cyc("aluwb", v(0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,4'd0,0));
    endtask

    task automatic do_br(input logic [2:0] f3, input logic z,
                         input logic tk);
        setin(7'b1100011, f3, 1'b0);
        Zero = ~z;
        fetch_decode(2'd2, 0);
        cyc("branch", v(0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,4'd8,0));
        cyc("brwait", v(0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,4'd8,0));
        Zero = z;
        cyc("brchk", v(0,0,0,0,0,2'd0,2'd0,2'd0,2'd2,4'd0,0));
        Zero = ~z;
        if (tk) begin
            cyc("brtgt", v(0,0,0,0,0,2'd0,2'd1,2'd1,2'd2,4'd0,0));
            cyc("br_pcwb", v(1,0,0,0,0,2'd0,2'd0,2'd0,2'd2,4'd0,0));
        end
    endtask

    task automatic do_jal();
        setin(7'b1101111, 3'b000, 1'b0);
        fetch_decode(2'd3, 0);
        cyc("jal", v(0,0,0,0,1,2'd2,2'd1,2'd1,2'd3,4'd0,0));
        cyc("jal_pcwb", v(1,0,0,0,0,2'd0,2'd0,2'd0,2'd3,4'd0,0));
    endtask

    task automatic do_ill(input logic [6:0] o, input logic [2:0] f3,
                          input logic [1:0] imm);
        setin(o, f3, 1'b0);
        fetch_decode(imm, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        cyc("idle_rst", v(0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,4'd0,0));
        cyc("idle_rst", v(0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,4'd0,0));
        reset = 1'b0;
        cyc("idle_dly0", v(0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,4'd0,0));
        cyc("idle_dly1", v(0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,4'd0,0));

        do_lw();
        do_alu(7'b0110011, 3'b000, 1'b1, 1'b0, 4'b1000);
        do_alu(7'b0110011, 3'b101, 1'b1, 1'b0, 4'b1101);
        do_alu(7'b0010011, 3'b000, 1'b1, 1'b1, 4'b0000);
        do_alu(7'b0010011, 3'b101, 1'b1, 1'b1, 4'b1101);
        do_br(3'b000, 1'b1, 1'b1);
        do_br(3'b000, 1'b0, 1'b0);
        do_br(3'b001, 1'b1, 1'b0);
        do_br(3'b001, 1'b0, 1'b1);
        do_jal();
        do_ill(7'b0000000, 3'b000, 2'd0);
        do_ill(7'b1100011, 3'b010, 2'd2);
        do_lw();

        // sw interrupted by reset in the middle of MEMWRITE
        setin(7'b0100011, 3'b010, 1'b0);
        fetch_decode(2'd1, 0);
        cyc("sw_memadr", v(0,0,0,0,0,2'd0,2'd2,2'd1,2'd1,4'd0,0));
        q.push_back('{"sw_memwrite", v(0,1,1,0,0,2'd0,2'd0,2'd0,2'd1,4'd0,0)});
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_chk++;
        if (act !== v(0,0,0,0,0,2'd0,2'd0,2'd0,2'd1,4'd0,0)) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected %b", act,
                     v(0,0,0,0,0,2'd0,2'd0,2'd0,2'd1,4'd0,0));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            cyc("idle_hold", v(0,0,0,0,0,2'd0,2'd0,2'd0,2'd1,4'd0,0));
        reset = 1'b0;
        cyc("idle_rel0", v(0,0,0,0,0,2'd0,2'd0,2'd0,2'd1,4'd0,0));
        cyc("idle_rel1", v(0,0,0,0,0,2'd0,2'd0,2'd0,2'd1,4'd0,0));
        do_jal();

        repeat (3) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
